print_arbiter: RTL and testbench

PRINT_ARBITER -- requirements
Module: print_arbiter

---
 rtl/print_arbiter.sv | 170 +++++++++++++++++
 tb/tb_print_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/print_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : print_arbiter
//  Description : Round-robin, message-atomic arbiter that merges byte streams
//                from NREQ requesters into one UART transmit byte stream.
//                A granted requester keeps ownership until its last byte is
//                accepted or until it stalls for TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module print_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                timeout_evt
);

    // Index width for requester numbers; stall counter is at least 16 bits
    // and wide enough to hold TIMEOUT-1.
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = (TIMEOUT > 65536) ? $clog2(TIMEOUT) : 16;

    localparam logic [SW-1:0]   STALL_LIMIT = SW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   LAST_IDX    = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0    = NREQ'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   gidx;          // index of the current owner
    logic [IW-1:0]   ptr;           // round-robin search start
    logic [SW-1:0]   stall_cnt;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            out_free;      // output register can take a byte this cycle
    logic            accept;
    logic            accept_last;
    logic            stall_hit;
    logic [IW-1:0]   ptr_after;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        int c;
        c          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!pick_found && req_valid[IW'(c)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(c);
            end
        end
    end

    // Handshake terms for the granted requester and the stall timeout.
    always_comb begin
        out_free    = !out_valid || out_ready;
        accept      = (state == XFER) && req_valid[gidx] && out_free;
        accept_last = accept && req_last[gidx];
        // A byte accepted on the limit cycle always wins over the timeout.
        stall_hit   = (state == XFER) && !accept && (stall_cnt == STALL_LIMIT);
        ptr_after   = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and combinational outputs.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        busy      = out_valid;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                busy      = 1'b1;
                req_ready = grant & {NREQ{out_free}};
                if (accept_last || stall_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ownership: load on arbitration, release on last byte or timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
        end else if (state == IDLE) begin
            if (pick_found) begin
                grant <= ONE_HOT0 << pick_idx;
                gidx  <= pick_idx;
            end
        end else if (accept_last || stall_hit) begin
            grant <= '0;
            ptr   <= ptr_after;
        end
    end

    // Stall counter: cleared on grant and on every accepted byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (state == IDLE) begin
            stall_cnt <= '0;
        end else if (accept || stall_hit) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Single output register towards the transmitter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= req_data[{gidx, 3'b000} +: 8];
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // One-cycle pulse when a grant is revoked for stalling.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= stall_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_print_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_print_arbiter
//  Description : Scoreboard bench for print_arbiter. Directed messages are
//                queued per requester; expected output bytes and grants are
//                queued alongside and checked by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_print_arbiter;

    localparam int N  = 4;
    localparam int TO = 12;

    logic             clk;
    logic             resetn;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     grant;
    logic             busy;
    logic             timeout_evt;

    print_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [8:0]    txq [N][$];      // {last, data} per requester
    logic [7:0]    exp_bytes [$];
    logic [N-1:0]  exp_grant [$];
    bit            chk_gap = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int r, input logic [7:0] d, input logic last, input bit expect_out);
        txq[r].push_back({last, d});
        if (expect_out) begin
            exp_bytes.push_back(d);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            done = !busy && (req_valid == '0) && (txq[0].size() == 0) && (txq[1].size() == 0)
                   && (txq[2].size() == 0) && (txq[3].size() == 0);
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_out_valid(input string name);
        for (int k = 0; k < 50 && !out_valid; k++) begin
            tick();
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    // Requester models: present queue heads, pop on observed handshake.
    initial begin
        logic [N-1:0] fire;
        logic [8:0]   head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && txq[i].size() > 0) begin
                    void'(txq[i].pop_front());
                end
                if (txq[i].size() > 0) begin
                    head               = txq[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = head[7:0];
                    req_last[i]        = head[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: output bytes, grant order and inter-message idle gap.
    initial begin
        logic [N-1:0] prev_g;
        logic [7:0]   eb;
        logic [N-1:0] eg;
        int           zero_run;
        prev_g   = '0;
        zero_run = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_byte: got unexpected %02h, required no byte", out_data);
                end else begin
                    eb = exp_bytes.pop_front();
                    check("out_byte", 32'(out_data), 32'(eb));
                end
            end
            if (grant == '0) begin
                zero_run++;
            end else begin
                if (prev_g == '0) begin
                    if (exp_grant.size() == 0) begin
                        n_checks++;
                        $display("FAIL grant_order: got unexpected grant %0h, required none", grant);
                    end else begin
                        eg = exp_grant.pop_front();
                        check("grant_order", 32'(grant), 32'(eg));
                    end
                    if (chk_gap) begin
                        check("idle_gap", 32'(zero_run), 32'd1);
                    end
                end
                zero_run = 0;
            end
            prev_g = grant;
        end
    end

    initial begin
        bit stable;
        bit rdy_low;
        bit early;
        resetn    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_evt", 32'(timeout_evt), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        resetn = 1'b1;
        tick();

        // Single requester 1: 41, 42, 0A(last)
        put(1, 8'h41, 1'b0, 1'b1);
        put(1, 8'h42, 1'b0, 1'b1);
        put(1, 8'h0A, 1'b1, 1'b1);
        exp_grant.push_back(4'b0010);
        tick();
        check("single_grant_before", 32'(grant), 32'd0);
        tick();
        check("single_grant", 32'(grant), 32'b0010);
        check("single_req_ready", 32'(req_ready), 32'b0010);
        repeat (3) tick();
        check("single_grant_released", 32'(grant), 32'd0);
        check("single_last_byte", 32'(out_data), 32'h0A);
        wait_idle("single_idle");

        // Pointer now at 2: requesters 0 and 2 both ask, 2 must win first
        put(2, 8'h22, 1'b1, 1'b1);
        put(0, 8'h20, 1'b1, 1'b1);
        exp_grant.push_back(4'b0100);
        exp_grant.push_back(4'b0001);
        wait_idle("ptr_idle");

        // Backpressure on requester 0
        put(0, 8'h10, 1'b0, 1'b1);
        put(0, 8'h11, 1'b0, 1'b1);
        put(0, 8'h12, 1'b0, 1'b1);
        put(0, 8'h13, 1'b1, 1'b1);
        exp_grant.push_back(4'b0001);
        wait_out_valid("bp_first_byte");
        out_ready = 1'b0;
        stable    = 1'b1;
        rdy_low   = 1'b1;
        repeat (10) begin
            tick();
            if (out_data != 8'h10 || !out_valid) stable = 1'b0;
            if (req_ready != '0) rdy_low = 1'b0;
        end
        check("bp_data_stable", 32'(stable), 32'd1);
        check("bp_req_ready_low", 32'(rdy_low), 32'd1);
        check("bp_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        wait_idle("bp_idle");

        // Timeout: requester 2 sends one non-last byte then goes quiet
        put(2, 8'h55, 1'b0, 1'b1);
        exp_grant.push_back(4'b0100);
        wait_out_valid("to_first_byte");
        put(3, 8'h77, 1'b1, 1'b1);
        exp_grant.push_back(4'b1000);
        early = 1'b0;
        repeat (TO - 1) begin
            tick();
            if (timeout_evt) early = 1'b1;
        end
        check("to_no_early_evt", 32'(early), 32'd0);
        tick();
        check("to_evt", 32'(timeout_evt), 32'd1);
        check("to_grant_cleared", 32'(grant), 32'd0);
        tick();
        check("to_evt_one_cycle", 32'(timeout_evt), 32'd0);
        check("to_next_grant", 32'(grant), 32'b1000);
        // Remaining byte of requester 2 arrives under a fresh grant
        put(2, 8'h56, 1'b1, 1'b1);
        exp_grant.push_back(4'b0100);
        wait_idle("to_idle");

        // Last byte accepted exactly when the stall counter is at TO-1
        put(1, 8'h61, 1'b0, 1'b1);
        exp_grant.push_back(4'b0010);
        wait_out_valid("co_first_byte");
        repeat (TO - 2) tick();
        put(1, 8'h62, 1'b1, 1'b1);
        repeat (2) tick();
        check("co_no_evt", 32'(timeout_evt), 32'd0);
        check("co_grant_released", 32'(grant), 32'd0);
        check("co_last_byte", 32'(out_data), 32'h62);
        tick();
        check("co_no_evt_after", 32'(timeout_evt), 32'd0);
        wait_idle("co_idle");

        // Asynchronous reset mid-message with a pending output byte
        out_ready = 1'b0;
        put(3, 8'hC1, 1'b0, 1'b0);
        put(3, 8'hC2, 1'b0, 1'b0);
        put(3, 8'hC3, 1'b1, 1'b0);
        exp_grant.push_back(4'b1000);
        wait_out_valid("ar_pending_byte");
        #2;
        resetn = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_out_data", 32'(out_data), 32'd0);
        for (int i = 0; i < N; i++) begin
            txq[i].delete();
        end
        // Round-robin traffic queued while still in reset
        put(0, 8'h80, 1'b0, 1'b1);
        put(0, 8'h81, 1'b1, 1'b1);
        put(1, 8'h90, 1'b0, 1'b1);
        put(1, 8'h91, 1'b1, 1'b1);
        put(2, 8'hA0, 1'b0, 1'b1);
        put(2, 8'hA1, 1'b1, 1'b1);
        put(3, 8'hB0, 1'b0, 1'b1);
        put(3, 8'hB1, 1'b1, 1'b1);
        put(0, 8'h84, 1'b0, 1'b1);
        put(0, 8'h85, 1'b1, 1'b1);
        exp_grant.push_back(4'b0001);
        exp_grant.push_back(4'b0010);
        exp_grant.push_back(4'b0100);
        exp_grant.push_back(4'b1000);
        exp_grant.push_back(4'b0001);
        out_ready = 1'b1;
        tick();
        resetn = 1'b1;
        tick();
        check("ar_first_grant_lowest", 32'(grant), 32'b0001);
        check("ar_no_byte_after_release", 32'(out_valid), 32'd0);
        tick();
        chk_gap = 1'b1;
        wait_idle("rr_idle");
        chk_gap = 1'b0;

        check("exp_bytes_drained", 32'(exp_bytes.size()), 32'd0);
        check("exp_grants_drained", 32'(exp_grant.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
